// File: rtl/imem_loader.sv
// Serial byte loader for the instruction memory: assembles little-endian words from a
// byte stream, writes them at consecutive word addresses and holds the core until done.
module imem_loader #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [10:0]      loadWords,
    input  logic [7:0]       byteData,
    input  logic             byteValid,
    output logic             byteReady,
    input  logic [Width-1:0] pcAddress,
    output logic [Width-1:0] memAddress,
    output logic [Width-1:0] memWriteData,
    output logic             memWriteEnable,
    output logic             coreHold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned Bytes = Width / 8;
    localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

    state_e            state_q, state_d;
    logic [10:0]       words_q, words_d;
    logic [10:0]       word_idx_q, word_idx_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [Width-1:0]  asm_q, asm_d;
    logic [Width-1:0]  wdata_q, wdata_d;
    logic              error_q, error_d;
    logic              done_seen_q, done_seen_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            words_q     <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
            error_q     <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            wdata_q     <= wdata_d;
            error_q     <= error_d;
            done_seen_q <= done_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        error_d     = 1'b0;
        done_seen_d = done_seen_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(loadWords) > Depth) begin
                        error_d = 1'b1;
                    end else if (loadWords == 11'd0) begin
                        state_d = DONE;
                    end else begin
                        words_d    = loadWords;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (byteValid) begin
                    asm_d[byte_cnt_q*8 +: 8] = byteData;
                    // the completed word is captured separately so memWriteData never shows a partial word
                    if (byte_cnt_q == CntW'(Bytes - 1)) begin
                        wdata_d    = asm_d;
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 11'd1;
                state_d    = (word_idx_q + 11'd1 == words_q) ? DONE : LOAD;
            end
            DONE: begin
                done_seen_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign byteReady      = (state_q == LOAD);
    assign busy           = (state_q == LOAD) || (state_q == WRITE);
    assign memWriteEnable = (state_q == WRITE);
    assign done           = (state_q == DONE);
    assign error          = error_q;
    // hold the core out of fetch until the first complete load, and during any later load
    assign coreHold       = (state_q != IDLE) || !done_seen_q;
    assign memAddress     = busy ? Width'({word_idx_q, 2'b00}) : pcAddress;
    assign memWriteData   = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a byte-stream reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] loadWords;
    logic [7:0]  byteData;
    logic        byteValid;
    logic        byteReady;
    logic [31:0] pcAddress;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWriteEnable;
    logic        coreHold;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int d0, e0, n;
    logic [63:0] wr_q[$];
    logic [7:0]  bytes[$];

    imem_loader #(.Width(32), .Depth(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loadWords(loadWords),
        .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
        .pcAddress(pcAddress), .memAddress(memAddress), .memWriteData(memWriteData),
        .memWriteEnable(memWriteEnable), .coreHold(coreHold), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memWriteEnable) wr_q.push_back({memAddress, memWriteData});
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
    endfunction

    task automatic expect_writes(input int nw);
        chk32("write_count", 32'(wr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            chk32("write_addr", wr_q[i][63:32], 32'(4 * i));
            chk32("write_data", wr_q[i][31:0], model_word(i));
        end
    endtask

    task automatic do_start(input int nw);
        start     = 1'b1;
        loadWords = 11'(nw);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // presents one byte after 'gap' idle cycles and returns once it has been accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        byteValid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            byteData = 8'($urandom);
            @(negedge clk);
        end
        byteData  = b;
        byteValid = 1'b1;
        for (int w = 0; w < 20 && !byteReady; w++) @(negedge clk);
        chk1("byte_ready_wait", byteReady, 1'b1);
        @(negedge clk);
        byteValid = 1'b0;
        byteData  = 8'($urandom);
    endtask

    task automatic random_bytes(input int nw);
        bytes.delete();
        for (int i = 0; i < 4 * nw; i++) bytes.push_back(8'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; loadWords = '0; byteData = '0; byteValid = 1'b0;
        pcAddress = 32'h100;
        repeat (3) @(negedge clk);
        chk1("rst_hold", coreHold, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", byteReady, 1'b0);
        chk1("rst_we", memWriteEnable, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk32("rst_wdata", memWriteData, 32'h0);
        chk32("rst_addr_pc", memAddress, 32'h100);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("hold_before_first_done", coreHold, 1'b1);

        // two-word reference program
        bytes = '{8'h63, 8'h02, 8'hF0, 8'h05, 8'h33, 8'h8D, 8'hDE, 8'h01};
        wr_q.delete(); d0 = done_cnt;
        do_start(2);
        chk1("load_busy", busy, 1'b1);
        chk32("load_addr", memAddress, 32'h0);
        for (int i = 0; i < 8; i++) send_byte(bytes[i], 0);
        chk1("w2_we", memWriteEnable, 1'b1);
        chk32("w2_addr", memAddress, 32'h4);
        chk32("w2_data", memWriteData, 32'h01DE8D33);
        @(negedge clk);
        chk1("w2_done", done, 1'b1);
        chk1("w2_done_hold", coreHold, 1'b1);
        chk1("w2_done_busy", busy, 1'b0);
        @(negedge clk);
        chk1("w2_done_pulse", done, 1'b0);
        chk1("w2_hold_released", coreHold, 1'b0);
        @(negedge clk);
        expect_writes(2);
        chk32("w2_first_word", wr_q.size() > 0 ? wr_q[0][31:0] : 32'h0, 32'h05F00263);
        chk32("w2_done_count", 32'(done_cnt - d0), 32'd1);
        chk32("w2_wdata_held", memWriteData, 32'h01DE8D33);

        // zero-length load
        wr_q.delete(); d0 = done_cnt;
        do_start(0);
        chk1("zero_done", done, 1'b1);
        chk1("zero_we", memWriteEnable, 1'b0);
        chk1("zero_hold", coreHold, 1'b1);
        @(negedge clk);
        chk1("zero_done_pulse", done, 1'b0);
        chk1("zero_hold_released", coreHold, 1'b0);
        repeat (2) @(negedge clk);
        chk32("zero_writes", 32'(wr_q.size()), 32'd0);
        chk32("zero_done_count", 32'(done_cnt - d0), 32'd1);

        // oversize load rejected
        e0 = err_cnt;
        do_start(1025);
        chk1("big_error", error, 1'b1);
        chk1("big_ready", byteReady, 1'b0);
        chk1("big_busy", busy, 1'b0);
        @(negedge clk);
        chk1("big_error_pulse", error, 1'b0);
        chk1("big_ready_after", byteReady, 1'b0);
        chk1("big_hold", coreHold, 1'b0);
        @(negedge clk);
        chk32("big_error_count", 32'(err_cnt - e0), 32'd1);

        // one word, byteValid toggling every other cycle
        random_bytes(1);
        wr_q.delete(); d0 = done_cnt;
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(bytes[i], 1);
        repeat (3) @(negedge clk);
        expect_writes(1);
        chk32("gap_done_count", 32'(done_cnt - d0), 32'd1);

        // reset in the middle of a load
        random_bytes(2);
        wr_q.delete();
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
        chk32("mid_writes_before_rst", 32'(wr_q.size()), 32'd1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_hold", coreHold, 1'b1);
        chk1("mid_rst_ready", byteReady, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_we", memWriteEnable, 1'b0);
        chk32("mid_rst_wdata", memWriteData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk32("mid_no_more_writes", 32'(wr_q.size()), 32'd1);
        chk1("mid_hold_after_rst", coreHold, 1'b1);
        chk1("mid_idle", busy, 1'b0);
        random_bytes(1);
        wr_q.delete(); d0 = done_cnt;
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(bytes[i], 0);
        repeat (3) @(negedge clk);
        expect_writes(1);
        chk1("fresh_hold_released", coreHold, 1'b0);

        // fetch address passthrough and start ignored mid-load
        pcAddress = 32'h44;
        #1;
        chk32("pc_passthrough", memAddress, 32'h44);
        random_bytes(1);
        wr_q.delete(); d0 = done_cnt;
        do_start(1);
        send_byte(bytes[0], 0);
        send_byte(bytes[1], 0);
        do_start(3);
        chk1("restart_ignored_busy", busy, 1'b1);
        chk32("restart_loader_addr", memAddress, 32'h0);
        send_byte(bytes[2], 0);
        send_byte(bytes[3], 0);
        repeat (3) @(negedge clk);
        expect_writes(1);
        chk32("restart_done_count", 32'(done_cnt - d0), 32'd1);
        chk32("pc_after_load", memAddress, 32'h44);

        // randomized loads
        for (int it = 0; it < 10; it++) begin
            n = int'($urandom_range(1, 6));
            random_bytes(n);
            wr_q.delete(); d0 = done_cnt;
            pcAddress = $urandom;
            do_start(n);
            for (int i = 0; i < 4 * n; i++) send_byte(bytes[i], int'($urandom_range(0, 3)));
            for (int w = 0; w < 10 && !done; w++) @(negedge clk);
            chk1("rnd_done", done, 1'b1);
            repeat (2) @(negedge clk);
            expect_writes(n);
            chk32("rnd_done_count", 32'(done_cnt - d0), 32'd1);
            chk32("rnd_wdata_held", memWriteData, model_word(n - 1));
            chk32("rnd_pc_passthrough", memAddress, pcAddress);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: Width, 32, data/address width of the instruction memory port.
REQ-002 SHALL have parameter: Depth, 1024, instruction memory size in words.
REQ-003 SHALL have one clock; reset is asynchronous and active-low, on ports clk and rst_n.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port: loadWords  input  11  number of 32-bit words to load, sampled with start.
REQ-008 SHALL have port: byteData  input  8  serial program byte.
REQ-009 SHALL have port: byteValid  input  1  byteData valid.
REQ-010 SHALL have port: byteReady  output  1  loader accepts byte this cycle.
REQ-011 SHALL have port: pcAddress  input  Width  core fetch byte address.
REQ-012 SHALL have port: memAddress  output  Width  byte address to instruction memory.
REQ-013 SHALL have port: memWriteData  output  Width  assembled instruction word.
REQ-014 SHALL have port: memWriteEnable  output  1  one-cycle write strobe.
REQ-015 SHALL have port: coreHold  output  1  core must stall/stay in reset.
REQ-016 SHALL have port: busy  output  1  load in progress.
REQ-017 SHALL have port: done  output  1  one-cycle pulse on load completion.
REQ-018 SHALL have port: error  output  1  one-cycle pulse on rejected start.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-020 SHALL, in IDLE on start with 1<=loadWords<=Depth, latch loadWords, clear word index and byte count, enter LOAD.
REQ-021 SHALL, in IDLE on start with loadWords=0, go to DONE without any write.
REQ-022 SHALL, in IDLE on start with loadWords>Depth, pulse error next cycle and remain IDLE.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL drive byteReady=1 only in LOAD; a byte transfers when byteValid&&byteReady.
REQ-025 SHALL assemble little-endian: 1st byte -> bits 7:0, 2nd -> 15:8, 3rd -> 23:16, 4th -> 31:24.
REQ-026 SHALL, on the 4th accepted byte, enter WRITE next cycle; WRITE lasts exactly one cycle.
REQ-027 SHALL, in WRITE, assert memWriteEnable with memAddress=4*wordIndex and memWriteData=assembled word.
REQ-028 SHALL, after WRITE, increment wordIndex; go to DONE if wordIndex+1=loadWords, else LOAD.
REQ-029 SHALL pulse done for the single DONE cycle, then return to IDLE.
REQ-030 SHALL drive memAddress=pcAddress in IDLE and DONE; loader address in LOAD and WRITE.
REQ-031 SHALL assert busy in LOAD and WRITE.
REQ-032 SHALL assert coreHold in LOAD, WRITE and DONE, and from reset until the first done.
REQ-033 SHALL deassert coreHold in IDLE once any done has occurred; a new start reasserts it.
REQ-034 SHALL keep memWriteEnable low outside WRITE; memWriteData holds last assembled word.
REQ-035 SHALL tolerate byteValid gaps of any length in LOAD with no state change.

Reset
REQ-036 SHALL, on rst_n low, immediately force IDLE, byteReady=0, memWriteEnable=0, done=0, error=0, busy=0, coreHold=1, memWriteData=0, counters=0.
REQ-037 SHALL discard any partial word or partial load on reset; no write follows reset release.

Verification
REQ-038 SHALL verify: start, loadWords=2, bytes 63,02,F0,05,33,8D,DE,01 -> writes 05F00263@0 then 01DE8D33@4, done one cycle later, coreHold falls.
REQ-039 SHALL verify: start with loadWords=0 -> done next cycle, no memWriteEnable.
REQ-040 SHALL verify: start with loadWords=1025 -> error pulse, stays IDLE, byteReady stays 0.
REQ-041 SHALL verify: loadWords=1 with byteValid toggling every other cycle -> single correct write at address 0.
REQ-042 SHALL verify: rst_n low after 6 of 8 bytes -> IDLE, coreHold=1, no further write; fresh load succeeds.
REQ-043 SHALL verify: after done, pcAddress=0x44 -> memAddress=0x44; second start mid-load ignored.
